axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master
// Bridges a simple CPU request/response port onto an AXI4-Lite master
// interface. Only one transaction is in flight at a time. Every output
// comes either from a flop or from a decode of the state register, so no
// input reaches an output through combinational logic.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   req_*                  CPU request (valid/ready, we, addr, wdata, wstrb)
//   resp_*                 one-cycle completion pulse with rdata and error
//   AR*/R*/AW*/W*/B*_M     AXI4-Lite master channels
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a CPU request, req_ready high
// RD_ADDR | ARVALID_M high until ARREADY_M
// RD_DATA | RREADY_M high until RVALID_M, read data captured
// WR_REQ  | AWVALID_M / WVALID_M each high until their own handshake
// WR_RESP | BREADY_M high until BVALID_M
// RESP    | resp_valid high for one cycle, then back to IDLE
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   ARADDR_M,
    output logic                ARVALID_M,
    input  logic                ARREADY_M,
    input  logic [DATA_W-1:0]   RDATA_M,
    input  logic [1:0]          RRESP_M,
    input  logic                RVALID_M,
    output logic                RREADY_M,
    output logic [ADDR_W-1:0]   AWADDR_M,
    output logic                AWVALID_M,
    input  logic                AWREADY_M,
    output logic [DATA_W-1:0]   WDATA_M,
    output logic [DATA_W/8-1:0] WSTRB_M,
    output logic                WVALID_M,
    input  logic                WREADY_M,
    input  logic [1:0]          BRESP_M,
    input  logic                BVALID_M,
    output logic                BREADY_M
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                rready_q, rready_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    logic aw_hs;
    logic w_hs;

    // Only bit 1 of xRESP distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp_lsb;
    assign unused_resp_lsb = RRESP_M[0] ^ BRESP_M[0];

    assign aw_hs = awvalid_q && AWREADY_M;
    assign w_hs  = wvalid_q && WREADY_M;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        rready_d     = rready_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (ARREADY_M) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID_M) begin
                    rready_d     = 1'b0;
                    resp_rdata_d = RDATA_M;
                    resp_err_d   = RRESP_M[1];
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // A channel finishing this cycle counts as done already.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID_M) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = BRESP_M[1];
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            rready_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            rready_q     <= rready_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ARADDR_M   = addr_q;
    assign ARVALID_M  = arvalid_q;
    assign RREADY_M   = rready_q;
    assign AWADDR_M   = addr_q;
    assign AWVALID_M  = awvalid_q;
    assign WDATA_M    = wdata_q;
    assign WSTRB_M    = wstrb_q;
    assign WVALID_M   = wvalid_q;
    assign BREADY_M   = bready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ARADDR_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RVALID_M;
    logic        RREADY_M;
    logic [31:0] AWADDR_M;
    logic        AWVALID_M;
    logic        AWREADY_M;
    logic [31:0] WDATA_M;
    logic [3:0]  WSTRB_M;
    logic        WVALID_M;
    logic        WREADY_M;
    logic [1:0]  BRESP_M;
    logic        BVALID_M;
    logic        BREADY_M;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARADDR_M(ARADDR_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_pulses = 0;
    int exp_pulses = 0;

    // slave behaviour for the current transaction
    int          cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [1:0]  cfg_bresp = 2'b00;
    bit          cfg_spur = 0;

    // what the slave observed
    int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;
    logic [31:0] sl_ar_addr, sl_aw_addr, sl_w_data;
    logic [3:0]  sl_w_strb;
    int          sl_ar_cyc, sl_aw_cyc, sl_w_cyc;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    bit          r_pend = 0, sl_aw_done = 0, sl_w_done = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial forever begin
        @(negedge ACLK);
        if (resp_valid) resp_pulses++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural AXI-Lite slave: ready/valid decided at each falling edge.
    // A ready we drove last time together with a valid implies the handshake
    // happened at the rising edge in between (the master holds valid).
    initial begin
        ARREADY_M = 0; RVALID_M = 0; RDATA_M = '0; RRESP_M = '0;
        AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                ARREADY_M = 0; RVALID_M = 0; AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
                r_pend = 0; sl_aw_done = 0; sl_w_done = 0;
            end else if (cfg_spur) begin
                RVALID_M = 1; BVALID_M = 1; RDATA_M = $urandom; RRESP_M = 2'b10; BRESP_M = 2'b10;
            end else begin
                if (ARREADY_M) begin
                    ARREADY_M = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
                    chk("arvalid_drop", ARVALID_M, 0);
                end else if (ARVALID_M) begin
                    if (ar_cnt == 0) begin sl_ar_addr = ARADDR_M; sl_ar_cyc = cyc; end
                    else chk("araddr_stable", ARADDR_M, sl_ar_addr);
                    if (ar_cnt == cfg_ar_d) begin ARREADY_M = 1; ar_hs_n++; end
                    ar_cnt++;
                end
                if (RVALID_M) begin
                    RVALID_M = 0; RDATA_M = $urandom;
                end else if (r_pend) begin
                    chk("rready_held", RREADY_M, 1);
                    if (r_cnt == cfg_r_d) begin
                        RVALID_M = 1; RDATA_M = cfg_rdata; RRESP_M = cfg_rresp; r_pend = 0;
                    end
                    r_cnt++;
                end
                if (AWREADY_M) begin
                    AWREADY_M = 0; aw_cnt = 0; sl_aw_done = 1;
                    chk("awvalid_drop", AWVALID_M, 0);
                end else if (AWVALID_M) begin
                    if (aw_cnt == 0) begin sl_aw_addr = AWADDR_M; sl_aw_cyc = cyc; end
                    else chk("awaddr_stable", AWADDR_M, sl_aw_addr);
                    if (aw_cnt == cfg_aw_d) begin AWREADY_M = 1; aw_hs_n++; end
                    aw_cnt++;
                end
                if (WREADY_M) begin
                    WREADY_M = 0; w_cnt = 0; sl_w_done = 1;
                    chk("wvalid_drop", WVALID_M, 0);
                end else if (WVALID_M) begin
                    if (w_cnt == 0) begin sl_w_data = WDATA_M; sl_w_strb = WSTRB_M; sl_w_cyc = cyc; end
                    else chk("wdata_stable", {WSTRB_M, WDATA_M}, {sl_w_strb, sl_w_data});
                    if (w_cnt == cfg_w_d) begin WREADY_M = 1; w_hs_n++; end
                    w_cnt++;
                end
                if (BVALID_M) begin
                    BVALID_M = 0;
                end else if (sl_aw_done && sl_w_done) begin
                    chk("bready_held", BREADY_M, 1);
                    if (b_cnt == cfg_b_d) begin
                        BVALID_M = 1; BRESP_M = cfg_bresp;
                        sl_aw_done = 0; sl_w_done = 0; b_cnt = 0;
                    end else begin
                        b_cnt++;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns the cycle in which the request was taken.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit keep, output int acc);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
        while (!req_ready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("accept", req_ready, 1);
        acc = cyc;
        @(posedge ACLK);
        #1;
        if (!keep) req_valid = 0;
    endtask

    task automatic await_resp(input logic [31:0] exp_rdata, input bit exp_err,
                              input int exp_lat, input int acc, output int rc);
        int n = 0;
        bit got = 0;
        rc = -1;
        while (!got && n < 200) begin
            @(negedge ACLK);
            n++;
            chk("busy_not_ready", req_ready, 0);
            if (resp_valid) begin
                got = 1;
                rc = cyc;
                chk("latency", rc - acc, exp_lat);
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
                exp_pulses++;
            end
        end
        if (!got) chk("resp_timeout", 0, 1);
        @(negedge ACLK);
        chk("resp_one_cycle", resp_valid, 0);
        chk("rdata_hold", {resp_err, resp_rdata}, {exp_err, exp_rdata});
    endtask

    task automatic chk_channels(input bit we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int acc);
        if (!we) begin
            chk("ar_count", ar_hs_n, 1);
            chk("aw_count_rd", aw_hs_n + w_hs_n, 0);
            chk("araddr", sl_ar_addr, addr);
            chk("arvalid_cycle", sl_ar_cyc - acc, 1);
        end else begin
            chk("aw_w_count", {aw_hs_n[7:0], w_hs_n[7:0]}, 16'h0101);
            chk("ar_count_wr", ar_hs_n, 0);
            chk("awaddr", sl_aw_addr, addr);
            chk("wdata", {sl_w_strb, sl_w_data}, {strb, data});
            chk("awvalid_cycle", sl_aw_cyc - acc, 1);
            chk("wvalid_cycle", sl_w_cyc - acc, 1);
        end
    endtask

    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        int acc, rc, lat;
        logic [31:0] er;
        bit ee;
        ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0;
        issue(we, addr, data, strb, 0, acc);
        if (we) begin
            lat = 3 + imax(cfg_aw_d, cfg_w_d) + cfg_b_d;
            er = '0;
            ee = cfg_bresp[1];
        end else begin
            lat = 3 + cfg_ar_d + cfg_r_d;
            er = cfg_rdata;
            ee = cfg_rresp[1];
        end
        await_resp(er, ee, lat, acc, rc);
        chk_channels(we, addr, data, strb, acc);
    endtask

    task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
        cfg_ar_d = ar; cfg_r_d = r; cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b;
    endtask

    initial begin
        int acc1, acc2, rc1, rc2, n;
        bit we;
        ARESETn = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_ctrl", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, resp_valid, resp_err}, 0);
        chk("rst_data", {resp_rdata, ARADDR_M, WDATA_M, WSTRB_M}, 0);
        ARESETn = 1;
        #1;
        chk("rst_release_ready", req_ready, 1);
        @(negedge ACLK);

        // zero-wait read
        set_delays(0, 0, 0, 0, 0);
        cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
        run_txn(0, 32'h0000_0010, 32'h0, 4'h0);

        // write with AWREADY three cycles late, WREADY immediate
        set_delays(0, 0, 3, 0, 0);
        cfg_bresp = 2'b00;
        run_txn(1, 32'h0000_0020, 32'h12345678, 4'h3);

        // read, SLVERR, RVALID four cycles late
        set_delays(0, 4, 0, 0, 0);
        cfg_rdata = 32'hCAFE0001; cfg_rresp = 2'b10;
        run_txn(0, 32'h0000_0104, 32'h0, 4'h0);

        // zero-strobe write still goes out; DECERR flagged
        set_delays(0, 0, 1, 2, 1);
        cfg_bresp = 2'b11;
        run_txn(1, 32'hFFFF_FFFC, 32'hA5A5A5A5, 4'h0);

        // stray RVALID/BVALID while idle are ignored
        cfg_spur = 1;
        repeat (4) begin
            @(negedge ACLK);
            chk("spur_readies", {RREADY_M, BREADY_M, resp_valid, req_ready}, 4'b0001);
        end
        cfg_spur = 0;
        @(negedge ACLK);
        chk("spur_no_resp", resp_pulses, exp_pulses);

        // back-to-back read then write with req_valid held high
        set_delays(0, 0, 0, 0, 0);
        cfg_rdata = 32'h0BADF00D; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0;
        issue(0, 32'h40, 32'h0, 4'h0, 1, acc1);
        req_we = 1; req_addr = 32'h44; req_wdata = 32'h11223344; req_wstrb = 4'hF;
        await_resp(32'h0BADF00D, 0, 3, acc1, rc1);
        issue(1, 32'h44, 32'h11223344, 4'hF, 0, acc2);
        chk("b2b_accept_cycle", acc2 - rc1, 1);
        await_resp(32'h0, 0, 3, acc2, rc2);
        chk("b2b_hs", {ar_hs_n[7:0], aw_hs_n[7:0], w_hs_n[7:0]}, 24'h010101);

        // reset while waiting for BVALID
        set_delays(0, 0, 0, 0, 6);
        issue(1, 32'h80, 32'h55AA55AA, 4'hC, 0, acc1);
        n = 0;
        while (!BREADY_M && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("reach_wr_resp", BREADY_M, 1);
        #1 ARESETn = 0;
        #1;
        chk("abort_ctrl", {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, resp_valid}, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1;
        #1;
        chk("abort_ready", req_ready, 1);
        chk("abort_rdata", {resp_err, resp_rdata}, 0);
        chk("abort_no_resp", resp_pulses, exp_pulses);
        @(negedge ACLK);
        set_delays(1, 1, 0, 0, 0);
        cfg_rdata = 32'h600DCAFE; cfg_rresp = 2'b01;
        run_txn(0, 32'h0000_0200, 32'h0, 4'h0);

        // random traffic against the behavioural model
        for (int i = 0; i < 40; i++) begin
            set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 4));
            cfg_rdata = $urandom;
            cfg_rresp = 2'($urandom_range(0, 3));
            cfg_bresp = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            run_txn(we, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge ACLK);
        chk("total_resp_pulses", resp_pulses, exp_pulses);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
